// File: rtl/servo_pwm_multi_if.sv
// Write port bundle for servo_pwm_multi: per-channel pulse-width requests
// carried over a valid/ready handshake.
interface servo_pwm_multi_if #(
    parameter int NUM_CH    = 3,
    parameter int PERIOD_US = 20000
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int W    = $clog2(PERIOD_US + 1);

    logic            wr_valid;
    logic            wr_ready;
    logic [CH_W-1:0] wr_ch;
    logic [W-1:0]    wr_width;

    modport master (output wr_valid, output wr_ch, output wr_width, input wr_ready);
    modport slave  (input wr_valid, input wr_ch, input wr_width, output wr_ready);
endinterface

// File: rtl/servo_pwm_multi.sv
// N-channel hobby-servo PWM generator sharing one frame counter; writes are
// staged and committed at frame boundaries. Optional macro: SERVO_RAMP_EN.
module servo_pwm_multi #(
    parameter int NUM_CH       = 3,
    parameter int CLK_DIV      = 50,
    parameter int PERIOD_US    = 20000,
    parameter int MIN_US       = 1000,
    parameter int MAX_US       = 2000,
    parameter int RESET_US     = 1500,
    parameter int RAMP_STEP_US = 50
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    servo_pwm_multi_if.slave     wr_if,
    output logic [NUM_CH-1:0]    pwm_out,
    output logic                 frame_start
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int W    = $clog2(PERIOD_US + 1);
    localparam int WE   = W + 1;
    localparam int PW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [W-1:0]  FRAME_LAST = W'(PERIOD_US - 1);
    localparam logic [W-1:0]  MIN_W      = W'(MIN_US);
    localparam logic [W-1:0]  MAX_W      = W'(MAX_US);
    localparam logic [W-1:0]  RESET_W    = W'(RESET_US);

    logic [PW-1:0]     r_presc;
    logic [W-1:0]      r_us_cnt;
    logic [W-1:0]      r_pending [NUM_CH];
    logic [W-1:0]      r_active  [NUM_CH];
    logic [NUM_CH-1:0] r_pwm;
    logic              r_fs_arm;

    logic w_tick;
    logic w_commit;
    logic w_wr_fire;

    // Zero means off; otherwise the request is forced into [MIN_US, MAX_US].
    function automatic logic [W-1:0] clamp_width(input logic [W-1:0] req);
        logic [W-1:0] res;
        res = req;
        if (req == '0) begin
            res = '0;
        end else if (req < MIN_W) begin
            res = MIN_W;
        end else if (req > MAX_W) begin
            res = MAX_W;
        end else begin
            res = req;
        end
        return res;
    endfunction

    // One bounded step from cur toward tgt; switching to/from off is immediate.
    function automatic logic [W-1:0] ramp_step(input logic [W-1:0] cur,
                                               input logic [W-1:0] tgt);
        logic [WE-1:0] up_lim;
        logic [WE-1:0] dn_lim;
        logic [W-1:0]  res;
        up_lim = {1'b0, cur} + WE'(RAMP_STEP_US);
        dn_lim = {1'b0, tgt} + WE'(RAMP_STEP_US);
        res    = tgt;
        if ((cur == '0) || (tgt == '0)) begin
            res = tgt;
        end else if ({1'b0, tgt} > up_lim) begin
            res = up_lim[W-1:0];
        end else if ({1'b0, cur} > dn_lim) begin
            res = cur - W'(RAMP_STEP_US);
        end else begin
            res = tgt;
        end
        return res;
    endfunction

    assign w_tick         = (r_presc == PRESC_LAST);
    assign w_commit       = enable && w_tick && (r_us_cnt == FRAME_LAST);
    assign wr_if.wr_ready = rst_n && !w_commit;
    assign w_wr_fire      = wr_if.wr_valid && wr_if.wr_ready;

    // Microsecond prescaler and shared frame counter, parked at zero while stopped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc  <= '0;
            r_us_cnt <= '0;
        end else if (!enable) begin
            r_presc  <= '0;
            r_us_cnt <= '0;
        end else if (w_tick) begin
            r_presc  <= '0;
            r_us_cnt <= (r_us_cnt == FRAME_LAST) ? '0 : r_us_cnt + W'(1);
        end else begin
            r_presc  <= r_presc + PW'(1);
        end
    end

    // Pending widths: accepted writes land here; out-of-range channels match nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_pending[i] <= RESET_W;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_wr_fire && (wr_if.wr_ch == CH_W'(i))) begin
                    r_pending[i] <= clamp_width(wr_if.wr_width);
                end
            end
        end
    end

    // Active widths: follow pending while stopped, otherwise change only at commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_active[i] <= RESET_W;
            end
        end else if (!enable) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_active[i] <= r_pending[i];
            end
        end else if (w_commit) begin
            for (int i = 0; i < NUM_CH; i++) begin
`ifdef SERVO_RAMP_EN
                r_active[i] <= ramp_step(r_active[i], r_pending[i]);
`else
                r_active[i] <= r_pending[i];
`endif
            end
        end
    end

    // PWM flops and frame-start arming; armed after a commit or while stopped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm    <= '0;
            r_fs_arm <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_pwm[i] <= enable && (r_us_cnt < r_active[i]);
            end
            r_fs_arm <= w_commit || !enable;
        end
    end

    // Gating with enable makes the pulse land in the first enabled cycle.
    assign frame_start = enable && r_fs_arm;
    assign pwm_out     = r_pwm;

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Directed self-checking bench for servo_pwm_multi, scaled down to a
// 100 us frame at 2 clk/us so each frame is 200 clks.
module tb_servo_pwm_multi;
    localparam int NUM_CH     = 3;
    localparam int CLK_DIV    = 2;
    localparam int PERIOD_US  = 100;
    localparam int MIN_US     = 10;
    localparam int MAX_US     = 40;
    localparam int RESET_US   = 30;
    localparam int RAMP_US    = 5;
    localparam int FRAME_CLKS = PERIOD_US * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [2:0] pwm_out;
    logic       frame_start;
    int         checks = 0;
    int         errors = 0;

    servo_pwm_multi_if #(.NUM_CH(NUM_CH), .PERIOD_US(PERIOD_US)) wr_if ();

    servo_pwm_multi #(
        .NUM_CH(NUM_CH), .CLK_DIV(CLK_DIV), .PERIOD_US(PERIOD_US), .MIN_US(MIN_US),
        .MAX_US(MAX_US), .RESET_US(RESET_US), .RAMP_STEP_US(RAMP_US)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .wr_if(wr_if),
        .pwm_out(pwm_out), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic wait_fs();
        int n = 0;
        while (frame_start !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (frame_start !== 1'b1) begin
            errors++;
            $display("FAIL wait_fs timeout frame_start=%b expected 1", frame_start);
        end
    endtask

    // Counts high clks per channel over one frame, optionally issuing one write at clk wk.
    task automatic count_frame(input bit do_wr, input int wk, input logic [1:0] ch,
                               input logic [6:0] w, output int c [3]);
        c = '{0, 0, 0};
        for (int k = 0; k < FRAME_CLKS; k++) begin
            for (int i = 0; i < 3; i++) c[i] += int'(pwm_out[i]);
            if (do_wr && k == wk) begin
                wr_if.wr_valid = 1'b1;
                wr_if.wr_ch    = ch;
                wr_if.wr_width = w;
            end
            if (do_wr && k == wk + 1) wr_if.wr_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        enable = 1'b1;
        rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        checks += 3;
        if (pwm_out !== 3'b000) begin errors++; $display("FAIL reset_pwm got %b expected 000", pwm_out); end
        if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs got %b expected 0", frame_start); end
        if (wr_if.wr_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b expected 0", wr_if.wr_ready); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (wr_if.wr_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got %b expected 1", wr_if.wr_ready); end
    endtask

    task automatic test_default_frames();
        int c [3];
        wait_fs();
        count_frame(1'b0, 0, 2'd0, 7'd0, c);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (c[i] !== 60) begin errors++; $display("FAIL default_width ch%0d got %0d expected 60", i, c[i]); end
        end
        checks++;
        if (frame_start !== 1'b1) begin errors++; $display("FAIL frame_period fs=%b expected 1", frame_start); end
    endtask

    task automatic test_write_next_frame();
        int c [3];
        int e [3];
        count_frame(1'b1, 100, 2'd1, 7'd24, c);
        e = '{60, 60, 60};
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (c[i] !== e[i]) begin errors++; $display("FAIL write_same_frame ch%0d got %0d expected %0d", i, c[i], e[i]); end
        end
        count_frame(1'b0, 0, 2'd0, 7'd0, c);
        e = '{60, 48, 60};
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (c[i] !== e[i]) begin errors++; $display("FAIL write_next_frame ch%0d got %0d expected %0d", i, c[i], e[i]); end
        end
    endtask

    task automatic test_clamp_off();
        int c [3];
        int e [3];
        count_frame(1'b1, 100, 2'd0, 7'd5, c);
        count_frame(1'b1, 100, 2'd0, 7'd50, c);
        checks++;
        if (c[0] !== 20) begin errors++; $display("FAIL clamp_min got %0d expected 20", c[0]); end
        count_frame(1'b1, 100, 2'd0, 7'd0, c);
        checks++;
        if (c[0] !== 80) begin errors++; $display("FAIL clamp_max got %0d expected 80", c[0]); end
        count_frame(1'b1, 100, 2'd3, 7'd33, c);
        checks++;
        if (c[0] !== 0) begin errors++; $display("FAIL channel_off got %0d expected 0", c[0]); end
        count_frame(1'b0, 0, 2'd0, 7'd0, c);
        e = '{0, 48, 60};
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (c[i] !== e[i]) begin errors++; $display("FAIL bad_channel ch%0d got %0d expected %0d", i, c[i], e[i]); end
        end
    endtask

    task automatic test_commit_hold();
        int c [3];
        int n2 = 0;
        repeat (FRAME_CLKS - 1) @(negedge clk);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_ch    = 2'd2;
        wr_if.wr_width = 7'd36;
        #1;
        checks++;
        if (wr_if.wr_ready !== 1'b0) begin errors++; $display("FAIL commit_ready got %b expected 0", wr_if.wr_ready); end
        @(negedge clk);
        checks += 2;
        if (frame_start !== 1'b1) begin errors++; $display("FAIL commit_fs got %b expected 1", frame_start); end
        if (wr_if.wr_ready !== 1'b1) begin errors++; $display("FAIL post_commit_ready got %b expected 1", wr_if.wr_ready); end
        @(negedge clk);
        wr_if.wr_valid = 1'b0;
        for (int k = 1; k < FRAME_CLKS; k++) begin
            n2 += int'(pwm_out[2]);
            @(negedge clk);
        end
        checks++;
        if (n2 !== 60) begin errors++; $display("FAIL held_write_same_frame got %0d expected 60", n2); end
        count_frame(1'b0, 0, 2'd0, 7'd0, c);
        checks++;
        if (c[2] !== 72) begin errors++; $display("FAIL held_write_next_frame got %0d expected 72", c[2]); end
    endtask

    task automatic test_enable_toggle();
        int c [3];
        int e [3];
        count_frame(1'b1, 100, 2'd0, 7'd30, c);
        repeat (40) @(negedge clk);
        checks++;
        if (pwm_out[0] !== 1'b1) begin errors++; $display("FAIL pre_disable_pwm got %b expected 1", pwm_out[0]); end
        enable         = 1'b0;
        wr_if.wr_valid = 1'b1;
        wr_if.wr_ch    = 2'd1;
        wr_if.wr_width = 7'd12;
        @(negedge clk);
        checks += 2;
        if (pwm_out !== 3'b000) begin errors++; $display("FAIL disable_truncate got %b expected 000", pwm_out); end
        if (frame_start !== 1'b0) begin errors++; $display("FAIL disable_fs got %b expected 0", frame_start); end
        wr_if.wr_valid = 1'b0;
        repeat (4) @(negedge clk);
        enable = 1'b1;
        #1;
        checks++;
        if (frame_start !== 1'b1) begin errors++; $display("FAIL enable_fs got %b expected 1", frame_start); end
        count_frame(1'b0, 0, 2'd0, 7'd0, c);
        e = '{60, 24, 72};
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (c[i] !== e[i]) begin errors++; $display("FAIL reenable_frame ch%0d got %0d expected %0d", i, c[i], e[i]); end
        end
        checks++;
        if (frame_start !== 1'b1) begin errors++; $display("FAIL reenable_period fs=%b expected 1", frame_start); end
    endtask

    task automatic test_reset_mid_frame();
        int c [3];
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks += 2;
        if (pwm_out !== 3'b000) begin errors++; $display("FAIL midreset_pwm got %b expected 000", pwm_out); end
        if (wr_if.wr_ready !== 1'b0) begin errors++; $display("FAIL midreset_ready got %b expected 0", wr_if.wr_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        wait_fs();
        count_frame(1'b0, 0, 2'd0, 7'd0, c);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (c[i] !== 60) begin errors++; $display("FAIL midreset_width ch%0d got %0d expected 60", i, c[i]); end
        end
    endtask

`ifdef SERVO_RAMP_EN
    task automatic test_ramp();
        int c [3];
        count_frame(1'b1, 100, 2'd0, 7'd10, c);
        repeat (4) count_frame(1'b0, 0, 2'd0, 7'd0, c);
        checks++;
        if (c[0] !== 20) begin errors++; $display("FAIL ramp_down got %0d expected 20", c[0]); end
        count_frame(1'b1, 100, 2'd0, 7'd40, c);
        for (int n = 1; n <= 6; n++) begin
            count_frame(n == 6, 100, 2'd0, 7'd0, c);
            checks++;
            if (c[0] !== 2 * (10 + 5 * n)) begin
                errors++;
                $display("FAIL ramp_up frame%0d got %0d expected %0d", n, c[0], 2 * (10 + 5 * n));
            end
        end
        count_frame(1'b0, 0, 2'd0, 7'd0, c);
        checks++;
        if (c[0] !== 0) begin errors++; $display("FAIL ramp_off got %0d expected 0", c[0]); end
    endtask
`endif

    initial begin
        wr_if.wr_valid = 1'b0;
        wr_if.wr_ch    = 2'd0;
        wr_if.wr_width = 7'd0;
        @(negedge clk);
        test_reset();
        test_default_frames();
        test_write_next_frame();
        test_clamp_off();
        test_commit_hold();
        test_enable_toggle();
        test_reset_mid_frame();
`ifdef SERVO_RAMP_EN
        test_ramp();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
